regfile_sb: RTL
===============

Name: regfile_sb

Overview:
- Parametrised successor to the single-write-port CPU register file: N read ports and two write ports.
  - Port 0: ALU/writeback.
  - Port 1: late/multi-cycle results such as loads and the divider.
- Optional write-to-read bypass.
- Per-register pending-write scoreboard, so decode can stall on operands whose producer has not yet written back.
- Sits between decode (reads, pending marks) and writeback (both write ports).

Parameters:
- DW, 32, data width of each register.
- AW, 5, address width; depth = 2**AW registers.
- NREAD, 2, number of read ports (1..4).
- BYPASS, 1, 1 = same-cycle write data forwarded to reads; 0 = reads see state before the edge.
- ZERO_REG, 1, 1 = register 0 always reads 0, ignores writes and never becomes pending.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ra  in  NREAD*AW  read addresses, port k at bits [k*AW +: AW].
- rd  out  NREAD*DW  read data, port k at bits [k*DW +: DW].
- busy  out  NREAD  busy[k] = register ra[k] has an outstanding pending write.
- we0  in  1  write enable, port 0.
- wa0  in  AW  write address, port 0.
- wd0  in  DW  write data, port 0.
- we1  in  1  write enable, port 1 (late results; also clears pending).
- wa1  in  AW  write address, port 1.
- wd1  in  DW  write data, port 1.
- pset  in  1  mark register pa as pending.
- pa  in  AW  address to mark pending.
- npend  out  AW+1  count of registers currently pending.

Behaviour:
- Reset (rst_n low, async):
  - All registers cleared to 0.
  - All pending bits cleared; npend = 0.
  - Effect is immediate, not waiting for clk.
  - rd reflects cleared state combinationally (0 unless bypassed write data is present); busy = 0.
  - Writes and pset are ignored while rst_n is low.
  - Deassertion mid-operation needs no recovery sequence; the first post-reset edge operates normally.
- Writes, on the rising edge of clk:
  - we0 stores wd0 at wa0; we1 stores wd1 at wa1.
  - Same address on both ports in one cycle: port 0 data wins (younger instruction).
  - With ZERO_REG=1, any write to address 0 is discarded.
- Reads are combinational, zero latency:
  - ZERO_REG=1 and ra[k]==0 -> rd[k] = 0 and busy[k] = 0, regardless of writes.
  - Else if BYPASS=1 and we0 && wa0==ra[k] -> rd[k] = wd0.
  - Else if BYPASS=1 and we1 && wa1==ra[k] -> rd[k] = wd1.
  - Else rd[k] = stored register.
  - BYPASS=0: a read returns the new value only from the cycle after the write edge.
- Scoreboard (one bit per register), on the rising edge of clk:
  - pset sets bit pa. Ignored for pa==0 when ZERO_REG=1.
  - we1 clears bit wa1.
  - we0 does not touch pending bits.
  - pset and we1 to the same address in one cycle: set wins, leaving the bit pending (new producer issued).
  - pset to an already-pending register: no change; count not double-incremented.
  - we1 to a non-pending register: data written, bit stays 0.
- busy[k] is combinational:
  - busy[k] = pend[ra[k]].
  - With BYPASS=1 it is forced to 0 when we1 && wa1==ra[k] in the same cycle (value forwarded).
- npend:
  - Registered popcount of pending bits, updated at the same edge as the bits.
  - Range 0..2**AW-1 with ZERO_REG=1, 0..2**AW otherwise.
  - Never wraps.
- No width truncation: all data paths are DW bits; addresses are exactly AW bits, so no out-of-range case exists.

Decomposition:
- Shared package cpu_pkg:
  - DW/AW defaults.
  - Register index constants REG_ZERO=0, REG_V0=2, REG_A0=4, REG_T0=8, REG_T1=9, REG_S0=16, REG_S1=17, REG_SP=29, reused by debug taps and decode.
- One natural sub-module, regfile_sb_rport: a single read port (address compare, bypass mux, zero-reg and busy logic), instantiated NREAD times in a generate loop.
- Storage, write arbitration and scoreboard stay in the top module.

Test Plan:
- Reset: pulse rst_n low mid-cycle after writing 0xDEADBEEF to r8 and pset r9 -> rd for r8 = 0 immediately, busy for r9 = 0, npend = 0 before the next clk edge.
- Dual write, same address: we0 (r5, 0x11111111) and we1 (r5, 0x22222222) in one cycle -> next cycle ra=5 reads 0x11111111.
- Bypass: BYPASS=1, we0 (r3, 0xA5A5A5A5) while ra[0]=3 -> rd[0]=0xA5A5A5A5 in the same cycle. Repeat with BYPASS=0 -> old value, new value one cycle later.
- Zero register: we0 (r0, 0xFFFFFFFF), pset pa=0, ra[1]=0 -> rd[1]=0, busy[1]=0, npend unchanged.
- Scoreboard:
  - pset r7 -> next cycle busy=1 for ra=7, npend=1.
  - we1 r7 (0x1234) -> same-cycle busy=0 with rd=0x1234, then npend=0.
  - pset r7 together with we1 r7 -> r7 stays pending, npend holds.
- Full scoreboard: pset r1..r31 on successive cycles -> npend reaches 31. A repeat pset r31 leaves npend=31. Clearing all via we1 returns npend to 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU constants: default datapath widths and architectural register indices
// used by the register file, decode and debug taps.
package cpu_pkg;

    localparam int DW_DEF = 32;
    localparam int AW_DEF = 5;

    localparam int REG_ZERO = 0;
    localparam int REG_V0   = 2;
    localparam int REG_A0   = 4;
    localparam int REG_T0   = 8;
    localparam int REG_T1   = 9;
    localparam int REG_S0   = 16;
    localparam int REG_S1   = 17;
    localparam int REG_SP   = 29;

endpackage

// File: rtl/regfile_sb_rport.sv
// One combinational read port: zero-register handling, write-to-read forwarding
// and the operand busy flag derived from the pending bit of the addressed register.
module regfile_sb_rport
    import cpu_pkg::*;
#(
    parameter int DW       = DW_DEF,
    parameter int AW       = AW_DEF,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic [AW-1:0] ra_i,
    input  logic [DW-1:0] stored_i,
    input  logic          pend_i,
    input  logic          we0_i,
    input  logic [AW-1:0] wa0_i,
    input  logic [DW-1:0] wd0_i,
    input  logic          we1_i,
    input  logic [AW-1:0] wa1_i,
    input  logic [DW-1:0] wd1_i,
    output logic [DW-1:0] rd_o,
    output logic          busy_o
);

    logic hit0;
    logic hit1;
    logic is_zero;

    assign hit0    = (BYPASS != 0) && we0_i && (wa0_i == ra_i);
    assign hit1    = (BYPASS != 0) && we1_i && (wa1_i == ra_i);
    assign is_zero = (ZERO_REG != 0) && (ra_i == AW'(REG_ZERO));

    always_comb begin
        rd_o   = stored_i;
        busy_o = pend_i;
        if (is_zero) begin
            rd_o   = '0;
            busy_o = 1'b0;
        end else begin
            // Port 0 is the younger producer, so it takes priority when both match.
            if (hit0) begin
                rd_o = wd0_i;
            end else if (hit1) begin
                rd_o = wd1_i;
            end
            // A late result landing this cycle is forwarded, so the operand is ready.
            if (hit1) begin
                busy_o = 1'b0;
            end
        end
    end

endmodule

// File: rtl/regfile_sb.sv
// Two-write-port register file with NREAD combinational read ports and a
// per-register pending-write scoreboard with a registered pending count.
module regfile_sb
    import cpu_pkg::*;
#(
    parameter int DW       = DW_DEF,
    parameter int AW       = AW_DEF,
    parameter int NREAD    = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NREAD*AW-1:0] ra,
    output logic [NREAD*DW-1:0] rd,
    output logic [NREAD-1:0]    busy,
    input  logic                we0,
    input  logic [AW-1:0]       wa0,
    input  logic [DW-1:0]       wd0,
    input  logic                we1,
    input  logic [AW-1:0]       wa1,
    input  logic [DW-1:0]       wd1,
    input  logic                pset,
    input  logic [AW-1:0]       pa,
    output logic [AW:0]         npend
);

    localparam int DEPTH = 1 << AW;

    logic [DW-1:0]    mem_q [DEPTH];
    logic [DEPTH-1:0] pend_q;
    logic [DEPTH-1:0] pend_d;
    logic [AW:0]      npend_q;
    logic [AW:0]      npend_d;
    logic             wr0_ok;
    logic             wr1_ok;
    logic             pset_ok;

    assign wr0_ok  = we0  && !((ZERO_REG != 0) && (wa0 == AW'(REG_ZERO)));
    assign wr1_ok  = we1  && !((ZERO_REG != 0) && (wa1 == AW'(REG_ZERO)));
    assign pset_ok = pset && !((ZERO_REG != 0) && (pa  == AW'(REG_ZERO)));

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_reg
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    mem_q[gi] <= '0;
                end else if (wr0_ok && (wa0 == AW'(gi))) begin
                    mem_q[gi] <= wd0;
                end else if (wr1_ok && (wa1 == AW'(gi))) begin
                    mem_q[gi] <= wd1;
                end
            end
        end
    endgenerate

    // Set is applied after clear so a new producer issued alongside a writeback stays pending.
    always_comb begin
        pend_d = pend_q;
        if (we1) begin
            pend_d[wa1] = 1'b0;
        end
        if (pset_ok) begin
            pend_d[pa] = 1'b1;
        end
        npend_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            npend_d = npend_d + {{AW{1'b0}}, pend_d[i]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q  <= '0;
            npend_q <= '0;
        end else begin
            pend_q  <= pend_d;
            npend_q <= npend_d;
        end
    end

    assign npend = npend_q;

    generate
        for (genvar gi = 0; gi < NREAD; gi++) begin : g_rport
            logic [AW-1:0] ra_k;
            assign ra_k = ra[gi*AW +: AW];

            regfile_sb_rport #(
                .DW       (DW),
                .AW       (AW),
                .BYPASS   (BYPASS),
                .ZERO_REG (ZERO_REG)
            ) u_rport (
                .ra_i     (ra_k),
                .stored_i (mem_q[ra_k]),
                .pend_i   (pend_q[ra_k]),
                .we0_i    (we0),
                .wa0_i    (wa0),
                .wd0_i    (wd0),
                .we1_i    (we1),
                .wa1_i    (wa1),
                .wd1_i    (wd1),
                .rd_o     (rd[gi*DW +: DW]),
                .busy_o   (busy[gi])
            );
        end
    endgenerate

endmodule
